// File: rtl/fp_reg_file_if.sv
// Bus bundle between the FP register file and its users (FP ALU, mtc1/mfc1 path, branch unit).
// The master drives addresses, enables and write data; the slave returns read data and flags.
interface fp_reg_file_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cmp_en;
  logic [DATA_W-1:0] cmp_data;
  logic              mtc1_en;
  logic [ADDR_W-1:0] mtc1_addr;
  logic [DATA_W-1:0] mtc1_data;
  logic [ADDR_W-1:0] mfc1_addr;
  logic [DATA_W-1:0] mfc1_data;
  logic              fcc;
  logic              wr_collide;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, cmp_en, cmp_data,
           mtc1_en, mtc1_addr, mtc1_data, mfc1_addr,
    input  rd_data1, rd_data2, mfc1_data, fcc, wr_collide
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, cmp_en, cmp_data,
           mtc1_en, mtc1_addr, mtc1_data, mfc1_addr,
    output rd_data1, rd_data2, mfc1_data, fcc, wr_collide
  );
endinterface

// File: rtl/fp_reg_file.sv
// FP register file with write-through bypass on both ALU read ports and the mfc1 port,
// plus the FP condition flag (fcc) written by compare ops. ADDR_W must cover NUM_REGS.
module fp_reg_file #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic          clk,
  input logic          rst_n,
  fp_reg_file_if.slave bus
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              fcc_q, fcc_d;
  logic              wr_collide_q, wr_collide_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < ADDR_LIMIT;
  endfunction

  // Bypass order mirrors the write priority, so a read always shows what will be stored.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) val = regs_q[i];
    end
    if (in_range(addr) && bus.mtc1_en && (bus.mtc1_addr == addr)) val = bus.mtc1_data;
    if (in_range(addr) && bus.wr_en && (bus.wr_addr == addr))     val = bus.wr_data;
    // Reset must blank the outputs immediately, including any bypassed write data.
    if (!rst_n) val = '0;
    return val;
  endfunction

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so later statements override earlier ones and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.mtc1_en && (bus.mtc1_addr == ADDR_W'(i))) regs_d[i] = bus.mtc1_data;
      if (bus.wr_en && (bus.wr_addr == ADDR_W'(i)))     regs_d[i] = bus.wr_data;
    end
    fcc_d        = bus.cmp_en ? (bus.cmp_data != '0) : fcc_q;
    wr_collide_d = bus.wr_en && bus.mtc1_en && (bus.wr_addr == bus.mtc1_addr);
  end

  // NOTE: the register array is reset element by element because architectural state
  // must read +0.0 after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      fcc_q        <= 1'b0;
      wr_collide_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      fcc_q        <= fcc_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  assign bus.rd_data1   = read_port(bus.rd_addr1);
  assign bus.rd_data2   = read_port(bus.rd_addr2);
  assign bus.mfc1_data  = read_port(bus.mfc1_addr);
  assign bus.fcc        = fcc_q;
  assign bus.wr_collide = wr_collide_q;

endmodule
